// File: rtl/rps_pkg.sv
// rps_pkg: shared move/verdict encodings and match FSM states
package rps_pkg;

  localparam logic [1:0] STONE    = 2'b00;
  localparam logic [1:0] PAPER    = 2'b01;
  localparam logic [1:0] SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_INV = 2'b11;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [1:0] RES_INV = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    JUDGE   = 3'd2,
    SHOW    = 3'd3,
    DONE    = 3'd4
  } state_e;

  // saturating 4-bit increment used for the round counter
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rps_lock_latch.sv
// rps_lock_latch: per-player hidden move capture with a sticky lock flag
module rps_lock_latch
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       lock_i,
  input  logic [1:0] move_i,
  output logic [1:0] move_o,
  output logic       locked_o
);

  logic [1:0] move_q;
  logic       locked_q;

  // first lock of a round wins; clear wipes the move so it stays hidden
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_q   <= STONE;
      locked_q <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        move_q   <= STONE;
        locked_q <= 1'b0;
      end else if (lock_i && !locked_q) begin
        move_q   <= move_i;
        locked_q <= 1'b1;
      end
    end
  end

  assign move_o   = move_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/rps_match_controller.sv
// rps_match_controller: best-of-N match sequencer driving the judge core
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int JUDGE_LAT     = 2,
  parameter int SHOW_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       new_match,
  input  logic [1:0] p1_move,
  input  logic       p1_lock,
  input  logic [1:0] p2_move,
  input  logic       p2_lock,
  output logic [1:0] judge_p1,
  output logic [1:0] judge_p2,
  output logic       judge_start,
  input  logic [1:0] judge_result,
  output logic       round_valid,
  output logic [1:0] round_result,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] round_count,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] WIN_SCORE = 4'(ROUNDS_TO_WIN);
  localparam logic [3:0] JUDGE_END = 4'(JUDGE_LAT);
  localparam logic [3:0] SHOW_END  = 4'(SHOW_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       judge_start_q;
  logic       round_valid_q;
  logic [1:0] round_result_q;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic [3:0] round_count_q, round_count_d;
  logic       match_done_q;
  logic [1:0] match_winner_q;
  logic       lock1, lock2;
  logic       in_collect, show_end, clr_locks;

  assign in_collect = state_q == COLLECT;
  assign show_end   = state_q == SHOW && cnt_q == SHOW_END;
  assign clr_locks  = new_match | show_end;

  rps_lock_latch u_p1_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ena),
    .clr_i    (clr_locks),
    .lock_i   (p1_lock & in_collect),
    .move_i   (p1_move),
    .move_o   (judge_p1),
    .locked_o (lock1)
  );

  rps_lock_latch u_p2_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ena),
    .clr_i    (clr_locks),
    .lock_i   (p2_lock & in_collect),
    .move_i   (p2_move),
    .move_o   (judge_p2),
    .locked_o (lock2)
  );

  // score updates from the incoming verdict; invalid rounds are void
  always_comb begin
    p1_score_d    = p1_score_q + 4'(judge_result == RES_P1);
    p2_score_d    = p2_score_q + 4'(judge_result == RES_P2);
    round_count_d = (judge_result != RES_INV) ? sat_inc4(round_count_q) : round_count_q;
  end

  // match FSM with registered outputs; new_match overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      judge_start_q  <= 1'b0;
      round_valid_q  <= 1'b0;
      round_result_q <= RES_TIE;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      round_count_q  <= 4'd0;
      match_done_q   <= 1'b0;
      match_winner_q <= RES_TIE;
    end else if (ena) begin
      judge_start_q <= 1'b0;
      if (new_match) begin
        state_q        <= COLLECT;
        cnt_q          <= 4'd0;
        round_valid_q  <= 1'b0;
        p1_score_q     <= 4'd0;
        p2_score_q     <= 4'd0;
        round_count_q  <= 4'd0;
        match_done_q   <= 1'b0;
        match_winner_q <= RES_TIE;
      end else begin
        case (state_q)
          IDLE: ;
          COLLECT: begin
            if (lock1 && lock2) begin
              state_q       <= JUDGE;
              judge_start_q <= 1'b1;
              cnt_q         <= 4'd0;
            end
          end
          JUDGE: begin
            if (cnt_q == JUDGE_END) begin
              state_q        <= SHOW;
              cnt_q          <= 4'd0;
              round_result_q <= judge_result;
              round_valid_q  <= 1'b1;
              p1_score_q     <= p1_score_d;
              p2_score_q     <= p2_score_d;
              round_count_q  <= round_count_d;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          SHOW: begin
            if (show_end) begin
              cnt_q         <= 4'd0;
              round_valid_q <= 1'b0;
              if (p1_score_q == WIN_SCORE || p2_score_q == WIN_SCORE) begin
                state_q        <= DONE;
                match_done_q   <= 1'b1;
                match_winner_q <= (p1_score_q == WIN_SCORE) ? RES_P1 : RES_P2;
              end else begin
                state_q <= COLLECT;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign judge_start  = judge_start_q;
  assign round_valid  = round_valid_q;
  assign round_result = round_result_q;
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign round_count  = round_count_q;
  assign match_done   = match_done_q;
  assign match_winner = match_winner_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// tb_rps_match_controller: scoreboard bench with a behavioural match model and judge model
module tb_rps_match_controller;

  localparam int R    = 2;
  localparam int LAT  = 2;
  localparam int SHOW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd1, S_JUDGE = 3'd2, S_DONE = 3'd4;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, new_match = 1'b0;
  logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
  logic p1_lock = 1'b0, p2_lock = 1'b0;
  logic [1:0] judge_p1, judge_p2, judge_result, round_result, match_winner;
  logic judge_start, round_valid, match_done;
  logic [3:0] p1_score, p2_score, round_count;
  logic [2:0] state_dbg;

  rps_match_controller #(.ROUNDS_TO_WIN(R), .JUDGE_LAT(LAT), .SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .new_match(new_match),
    .p1_move(p1_move), .p1_lock(p1_lock), .p2_move(p2_move), .p2_lock(p2_lock),
    .judge_p1(judge_p1), .judge_p2(judge_p2), .judge_start(judge_start),
    .judge_result(judge_result), .round_valid(round_valid), .round_result(round_result),
    .p1_score(p1_score), .p2_score(p2_score), .round_count(round_count),
    .match_done(match_done), .match_winner(match_winner), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m1, m2, v;
    int p1, p2, rc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int m_p1 = 0, m_p2 = 0, m_rc = 0;
  int starts_seen = 0, exp_starts = 0;
  logic [1:0] verdict = 2'b00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] rps_verdict(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == b) return 2'b00;
    return ((int'(a) - int'(b) + 3) % 3 == 1) ? 2'b01 : 2'b10;
  endfunction

  // judge core model: verdict is valid only exactly LAT cycles after the start pulse
  initial begin
    logic [1:0] v;
    judge_result = 2'b00;
    forever begin
      @(negedge clk);
      if (judge_start === 1'b1) begin
        v = verdict;
        repeat (LAT) @(posedge clk);
        #1 judge_result = v;
        @(posedge clk);
        #1 judge_result = ~v;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (judge_start === 1'b1) starts_seen++;
  end

  // monitor: pops an expected round whenever the DUT starts showing a result
  initial begin
    logic prv;
    int len;
    exp_t e;
    prv = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv = 1'b0;
        len = 0;
      end else begin
        if (round_valid && !prv) begin
          if (sb.size() == 0) check("unexpected_round", 1, 0);
          else begin
            e = sb.pop_front();
            check("round_result", round_result, e.v);
            check("p1_score", p1_score, e.p1);
            check("p2_score", p2_score, e.p2);
            check("round_count", round_count, e.rc);
            check("judge_p1", judge_p1, e.m1);
            check("judge_p2", judge_p2, e.m2);
          end
        end
        if (round_valid) len++;
        else if (prv) begin
          check("show_len", len, SHOW);
          len = 0;
        end
        prv = round_valid;
      end
    end
  end

  task automatic check_zero(input string nm);
    check(nm, {judge_p1, judge_p2, judge_start, round_valid, round_result, p1_score, p2_score,
               round_count, match_done, match_winner, state_dbg}, 0);
  endtask

  task automatic wait_rv(input logic lvl);
    int n = 0;
    while (round_valid !== lvl && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (round_valid !== lvl) check("round_valid_timeout", round_valid, lvl);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (state_dbg !== s && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg !== s) check("state_timeout", state_dbg, s);
  endtask

  task automatic pulse(input bit first_p1, input logic [1:0] m);
    @(negedge clk);
    if (first_p1) begin p1_lock = 1'b1; p1_move = m; end
    else begin p2_lock = 1'b1; p2_move = m; end
    @(negedge clk);
    p1_lock = 1'b0; p2_lock = 1'b0;
    p1_move = 2'($urandom); p2_move = 2'($urandom);
  endtask

  task automatic pulse_both(input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    p1_lock = 1'b1; p1_move = a; p2_lock = 1'b1; p2_move = b;
    @(negedge clk);
    p1_lock = 1'b0; p2_lock = 1'b0;
    p1_move = 2'($urandom); p2_move = 2'($urandom);
  endtask

  task automatic start_match();
    @(negedge clk);
    new_match = 1'b1;
    @(negedge clk);
    new_match = 1'b0;
    m_p1 = 0; m_p2 = 0; m_rc = 0;
    check("nm_state", state_dbg, S_COLLECT);
    check("nm_scores", {p1_score, p2_score, round_count}, 0);
    check("nm_done_winner", {match_done, match_winner, round_valid}, 0);
    check("nm_hidden", {judge_p1, judge_p2}, 0);
  endtask

  // gap < 0 means both players lock in the same cycle
  task automatic issue_round(input logic [1:0] m1, input logic [1:0] m2, input int gap,
                             input bit first_p1, input bit extra);
    logic [1:0] v, own;
    exp_t e;
    v = rps_verdict(m1, m2);
    verdict = v;
    if (v == 2'b01) m_p1++;
    else if (v == 2'b10) m_p2++;
    if (v != 2'b11 && m_rc < 15) m_rc++;
    e.m1 = m1; e.m2 = m2; e.v = v; e.p1 = m_p1; e.p2 = m_p2; e.rc = m_rc;
    sb.push_back(e);
    exp_starts++;
    if (gap < 0) pulse_both(m1, m2);
    else begin
      own = first_p1 ? m1 : m2;
      pulse(first_p1, own);
      check("captured", first_p1 ? judge_p1 : judge_p2, own);
      check("other_hidden", first_p1 ? judge_p2 : judge_p1, 0);
      if (extra) begin
        pulse(first_p1, ~own);
        check("relock_ignored", first_p1 ? judge_p1 : judge_p2, own);
      end
      repeat (gap) @(negedge clk);
      pulse(!first_p1, first_p1 ? m2 : m1);
    end
  endtask

  task automatic finish_round();
    bit won;
    wait_rv(1'b1);
    wait_rv(1'b0);
    won = (m_p1 == R) || (m_p2 == R);
    check("post_state", state_dbg, won ? S_DONE : S_COLLECT);
    check("match_done", match_done, won);
    check("match_winner", match_winner, (m_p1 == R) ? 1 : (m_p2 == R) ? 2 : 0);
    check("locks_cleared", {judge_p1, judge_p2}, 0);
    check("start_count", starts_seen, exp_starts);
  endtask

  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input int gap,
                            input bit first_p1, input bit extra);
    issue_round(m1, m2, gap, first_p1, extra);
    finish_round();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_wait", state_dbg, S_IDLE);

    start_match();
    play_round(2'b00, 2'b10, 2, 1'b1, 1'b0);
    play_round(2'b01, 2'b01, -1, 1'b1, 1'b0);
    play_round(2'b11, 2'b00, 1, 1'b1, 1'b1);
    play_round(2'b00, 2'b10, 0, 1'b0, 1'b0);

    pulse_both(2'b01, 2'b00);
    repeat (8) @(negedge clk);
    check("done_hold_state", state_dbg, S_DONE);
    check("done_no_start", starts_seen, exp_starts);
    check("done_hold_score", {match_done, match_winner, p1_score}, {1'b1, 2'b01, 4'd2});

    for (int mt = 0; mt < 3; mt++) begin
      start_match();
      for (int r = 0; r < 40 && m_p1 < R && m_p2 < R; r++)
        play_round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)) - 1, 1'($urandom), 1'($urandom));
    end

    start_match();
    for (int r = 0; r < 17; r++) play_round(2'b10, 2'b10, -1, 1'b1, 1'b0);
    check("rc_saturate", round_count, 15);

    start_match();
    verdict = 2'b01;
    exp_starts++;
    pulse_both(2'b01, 2'b00);
    wait_state(S_JUDGE);
    new_match = 1'b1;
    @(negedge clk);
    new_match = 1'b0;
    check("abort_state", state_dbg, S_COLLECT);
    repeat (8) @(negedge clk);
    check("abort_scores", {p1_score, p2_score, round_count, round_valid}, 0);
    check("abort_state_hold", state_dbg, S_COLLECT);

    @(negedge clk);
    ena = 1'b0;
    p1_lock = 1'b1; p1_move = 2'b01; p2_lock = 1'b1; p2_move = 2'b10;
    repeat (3) @(negedge clk);
    p1_lock = 1'b0; p2_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("ena_no_capture", {judge_p1, judge_p2}, 0);
    check("ena_state", state_dbg, S_COLLECT);
    check("ena_no_start", starts_seen, exp_starts);
    ena = 1'b1;
    play_round(2'b10, 2'b00, 1, 1'b0, 1'b0);

    start_match();
    issue_round(2'b00, 2'b01, -1, 1'b1, 1'b0);
    wait_rv(1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_in_show");
    sb.delete();
    m_p1 = 0; m_p2 = 0; m_rc = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_zero("after_reset_idle");
    check("after_reset_starts", starts_seen, exp_starts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_match_controller.md
Name: rps_match_controller

Overview:
- Match sequencer that sits in front of the stone-paper-scissors judge core.
- Collects hidden moves from two players using per-player lock strobes, then drives the judge with a start pulse and samples its 2-bit verdict.
- Keeps scores and declares a best-of-N match winner.
- Move encoding: 00 stone, 01 paper, 10 scissors, 11 invalid. Verdict encoding: 00 tie, 01 P1, 10 P2, 11 invalid.

Parameters:
- ROUNDS_TO_WIN, 2: number of won rounds that ends the match (2 gives best of 3). Legal range 1..15.
- JUDGE_LAT, 2: cycles from the judge_start pulse to a valid judge_result. Legal range 1..7.
- SHOW_CYCLES, 4: cycles round_result is held with round_valid high. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  when low, the FSM and all counters freeze; outputs hold.
- new_match  in  1  single-cycle pulse that starts or restarts a match.
- p1_move  in  2  P1 move; sampled only on a p1_lock cycle.
- p1_lock  in  1  P1 lock-in strobe.
- p2_move  in  2  P2 move; sampled only on a p2_lock cycle.
- p2_lock  in  1  P2 lock-in strobe.
- judge_p1  out  2  captured P1 move presented to the judge.
- judge_p2  out  2  captured P2 move presented to the judge.
- judge_start  out  1  one-cycle start pulse to the judge.
- judge_result  in  2  judge verdict.
- round_valid  out  1  high while round_result is being shown.
- round_result  out  2  verdict of the last round.
- p1_score  out  4  P1 rounds won.
- p2_score  out  4  P2 rounds won.
- round_count  out  4  rounds played, saturating at 15.
- match_done  out  1  high in DONE.
- match_winner  out  2  01 P1, 10 P2, 00 when no winner yet.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE.
  - All outputs are 0 and both lock flags are cleared.
- ena low: no state, counter or flag changes; inputs are ignored, including new_match.
- IDLE: waits for new_match, then goes to COLLECT.
- new_match in any state (ena high) aborts the current match:
  - Scores, round_count, lock flags and match_winner are cleared.
  - round_valid and match_done drop.
  - Next state is COLLECT.
  - new_match takes priority over every other event in the same cycle.
- COLLECT:
  - The first pX_lock captures pX_move into judge_pX and sets lockX.
  - Further pX_lock pulses are ignored until the next round.
  - judge_pX reads 00 until captured, so moves stay hidden.
  - Both locks may arrive in the same cycle.
  - When lock1 and lock2 are both set, go to JUDGE.
- JUDGE:
  - judge_start is high on the first JUDGE cycle only.
  - A wait counter runs JUDGE_LAT cycles; judge_result is then registered into round_result.
  - Next state is SHOW.
- Scoring, applied on the same edge the result is registered:
  - 01 increments p1_score; 10 increments p2_score.
  - 00 (tie) and 11 (invalid) leave scores unchanged.
  - round_count increments for 00, 01 and 10 only; an invalid round is void and does not count.
- SHOW:
  - round_valid is high for exactly SHOW_CYCLES cycles, then the lock flags clear.
  - If either score equals ROUNDS_TO_WIN, go to DONE; otherwise go to COLLECT.
- DONE:
  - match_done is high; match_winner holds 01 or 10.
  - Scores and round_result hold.
  - Lock strobes are ignored; only new_match leaves DONE.
- Locks arriving in JUDGE or SHOW are ignored; they are not queued.
- Scores cannot exceed ROUNDS_TO_WIN, so no overflow handling is needed; round_count saturates at 15.
- Reset asserted mid-round forces IDLE immediately; no judge_start pulse is emitted afterwards.

Decomposition:
- Shared package rps_pkg holds:
  - Move constants: STONE, PAPER, SCISSORS, MOVE_INV.
  - Verdict constants: RES_TIE, RES_P1, RES_P2, RES_INV.
  - FSM state encodings: IDLE=0, COLLECT=1, JUDGE=2, SHOW=3, DONE=4.
- One natural sub-module, rps_lock_latch, instantiated once per player. It holds the capture register and lock flag, with clear and enable inputs.
- Timers and scoring stay in the top module.

Test Plan:
- Reset, then new_match; P1 locks 00; two cycles later P2 locks 10; judge returns 01 -> exactly one judge_start, judge_p1=00, judge_p2=10, p1_score=1, round_valid high for 4 cycles, back in COLLECT.
- Both players lock in the same cycle (01, 01); judge returns 00 -> scores unchanged, round_count=1, round_result=00.
- P1 locks 11; judge returns 11 -> scores unchanged and round_count unchanged; a second p1_lock pulse in COLLECT before P2 locks leaves judge_p1 unchanged.
- P1 wins two rounds -> DONE, match_done=1, match_winner=01; further lock pulses cause no judge_start; new_match clears everything and enters COLLECT.
- new_match pulsed during JUDGE -> no score update, scores stay 0, COLLECT next cycle; rst_n pulsed low during SHOW -> all outputs 0 and state_dbg=IDLE immediately.
- ena held low while both players lock -> no capture and no state change; after ena returns high, locks are accepted normally.
